// File: rtl/mul_frame_accum_pkg.sv
// Shared types and width rules for the multiplier back-end stages.
// Used by the frame accumulator and the MAC stages downstream.
package mul_frame_accum_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;

  // Extra carry bits kept above the result to detect saturation.
  localparam int SAT_GUARD_W = 1;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

  function automatic bit acc_w_ok(input int acc_w, input int prod_w);
    return acc_w >= prod_w;
  endfunction

endpackage

// File: rtl/mul_frame_accum_sat_add.sv
// Unsigned saturating adder: a + b clamped to W bits.
// ovf flags that the clamp was applied.
module sat_add_u
  import mul_frame_accum_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam int FW = W + SAT_GUARD_W;

  logic [FW-1:0] full;

  assign full = FW'(a) + FW'(b);
  assign ovf  = |full[FW-1:W];
  assign sum  = ovf ? '1 : full[W-1:0];

endmodule

// File: rtl/mul_frame_accum.sv
// Sums fixed-length frames of multiplier products into a saturating
// accumulator; results sit in a one-deep holding register (valid/ready).
module mul_frame_accum
  import mul_frame_accum_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              clr,
  input  logic              flush,
  input  logic              acc_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic              acc_ovf,
  output logic              drop_err,
  output logic              busy
);

  acc_state_t state, state_n;

  logic [ACC_W-1:0] acc, acc_n;
  logic [ACC_W-1:0] prod_ext, add_sum;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf_q, ovf_n;
  logic             add_ovf;
  logic             complete;
  logic             load;
  logic             drop;

  assign prod_ext = ACC_W'(prod_data);

  sat_add_u #(
    .W(ACC_W)
  ) u_add (
    .a  (acc),
    .b  (prod_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  always_comb begin
    acc_n = acc;
    cnt_n = cnt;
    ovf_n = ovf_q;
    if (prod_valid) begin
      acc_n = add_sum;
      cnt_n = cnt + CNT_W'(1);
      ovf_n = ovf_q | add_ovf;
    end
    // cnt_n is zero only when idle with no product: empty frames never emit
    complete = (cnt_n == CNT_W'(FRAME_LEN)) ||
               (flush && (cnt_n != '0));
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (prod_valid && !complete) state_n = ACCUM;
      ACCUM:   if (complete) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign load = complete && (!acc_valid || acc_ready);
  assign drop = complete && acc_valid && !acc_ready;
  assign busy = (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      if (complete) begin
        acc   <= '0;
        cnt   <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc   <= acc_n;
        cnt   <= cnt_n;
        ovf_q <= ovf_n;
      end
    end
  end

  // A fresh result may replace one being accepted this cycle: no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_cnt   <= '0;
      acc_ovf   <= 1'b0;
      drop_err  <= 1'b0;
    end else if (clr) begin
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_cnt   <= '0;
      acc_ovf   <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      if (load) begin
        acc_valid <= 1'b1;
        acc_data  <= acc_n;
        acc_cnt   <= cnt_n;
        acc_ovf   <= ovf_n;
      end else if (acc_ready) begin
        acc_valid <= 1'b0;
      end
      if (drop) drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_frame_accum.sv
// Directed bench for mul_frame_accum with a queue scoreboard.
// Two instances: default widths and a narrow 17-bit accumulator.
module tb_mul_frame_accum;

  typedef struct {
    logic [23:0] d;
    logic [2:0]  c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prod_valid;
  logic [15:0] prod_data;
  logic        clr;
  logic        flush;
  logic        acc_ready;
  logic        en17;
  logic        p17;

  logic        acc_valid;
  logic [23:0] acc_data;
  logic [2:0]  acc_cnt;
  logic        acc_ovf;
  logic        drop_err;
  logic        busy;

  logic        v17;
  logic [16:0] d17;
  logic [2:0]  c17;
  logic        o17;
  logic        de17;
  logic        b17;

  exp_t q[$];
  exp_t q17[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign p17 = prod_valid & en17;

  mul_frame_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prod_valid(prod_valid),
    .prod_data (prod_data),
    .clr       (clr),
    .flush     (flush),
    .acc_ready (acc_ready),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .acc_cnt   (acc_cnt),
    .acc_ovf   (acc_ovf),
    .drop_err  (drop_err),
    .busy      (busy)
  );

  mul_frame_accum #(
    .ACC_W(17)
  ) dut17 (
    .clk       (clk),
    .rst_n     (rst_n),
    .prod_valid(p17),
    .prod_data (prod_data),
    .clr       (clr),
    .flush     (flush),
    .acc_ready (acc_ready),
    .acc_valid (v17),
    .acc_data  (d17),
    .acc_cnt   (c17),
    .acc_ovf   (o17),
    .drop_err  (de17),
    .busy      (b17)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prod(input logic [15:0] d);
    prod_valid = 1'b1;
    prod_data  = d;
    step();
    prod_valid = 1'b0;
    prod_data  = '0;
  endtask

  task automatic push(input logic [23:0] d, input logic [2:0] c,
                      input logic o);
    exp_t e;
    e.d = d;
    e.c = c;
    e.o = o;
    q.push_back(e);
  endtask

  // Monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && acc_valid && acc_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0d expected none", acc_data);
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(acc_data), 32'(e.d));
        chk("out_cnt", 32'(acc_cnt), 32'(e.c));
        chk("out_ovf", 32'(acc_ovf), 32'(e.o));
      end
    end
    if (rst_n && v17 && acc_ready) begin
      if (q17.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out17: got %0d expected none", d17);
      end else begin
        e = q17.pop_front();
        chk("out17_data", 32'(d17), 32'(e.d));
        chk("out17_cnt", 32'(c17), 32'(e.c));
        chk("out17_ovf", 32'(o17), 32'(e.o));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n      = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    clr        = 1'b0;
    flush      = 1'b0;
    acc_ready  = 1'b1;
    en17       = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(acc_valid), 0);
    chk("rst_data", 32'(acc_data), 0);
    chk("rst_cnt", 32'(acc_cnt), 0);
    chk("rst_ovf", 32'(acc_ovf), 0);
    chk("rst_drop", 32'(drop_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step();

    // 1/2: four 255*255 products, wide and narrow accumulators
    en17 = 1'b1;
    push(24'd260100, 3'd4, 1'b0);
    e.d = 24'd131071;
    e.c = 3'd4;
    e.o = 1'b1;
    q17.push_back(e);
    prod(16'd65025);
    chk("t1_busy", 32'(busy), 1);
    prod(16'd65025);
    prod(16'd65025);
    prod(16'd65025);
    chk("t1_valid_lat", 32'(acc_valid), 1);
    chk("t1_busy_idle", 32'(busy), 0);
    chk("t2_ovf17", 32'(o17), 1);
    en17 = 1'b0;
    step();
    chk("t1_valid_drop", 32'(acc_valid), 0);

    // 3: partial frame via flush, then an empty flush
    push(24'd300, 3'd2, 1'b0);
    prod(16'd100);
    prod(16'd200);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_valid", 32'(acc_valid), 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_empty_flush", 32'(acc_valid), 0);
    step();
    chk("t3_empty_flush2", 32'(acc_valid), 0);

    // 4: overrun with acc_ready low
    acc_ready = 1'b0;
    push(24'd10, 3'd4, 1'b0);
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 4; i++) prod(16'(i));
    chk("t4_drop_err", 32'(drop_err), 1);
    chk("t4_held_data", 32'(acc_data), 10);
    chk("t4_held_valid", 32'(acc_valid), 1);
    acc_ready = 1'b1;
    step();
    chk("t4_valid_after", 32'(acc_valid), 0);
    chk("t4_drop_sticky", 32'(drop_err), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clr_drop", 32'(drop_err), 0);

    // 5: acceptance coincides with the next completion
    acc_ready = 1'b0;
    push(24'd4, 3'd4, 1'b0);
    push(24'd8, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) prod(16'd1);
    for (int i = 0; i < 3; i++) prod(16'd2);
    acc_ready = 1'b1;
    prod(16'd2);
    chk("t5_valid_kept", 32'(acc_valid), 1);
    chk("t5_data_next", 32'(acc_data), 8);
    step();
    chk("t5_valid_drop", 32'(acc_valid), 0);
    chk("t5_no_drop_err", 32'(drop_err), 0);

    // 6: reset mid-frame discards the partial sum
    prod(16'd7);
    prod(16'd9);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(acc_valid), 0);
    chk("t6_rst_data", 32'(acc_data), 0);
    chk("t6_rst_cnt", 32'(acc_cnt), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_drop", 32'(drop_err), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_no_out", 32'(acc_valid), 0);
    push(24'd20, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) prod(16'd5);
    chk("t6_valid", 32'(acc_valid), 1);
    step();
    step();

    chk("q_empty", 32'(q.size()), 0);
    chk("q17_empty", 32'(q17.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
